mem_bus_arbiter: RTL and testbench

- Shares the single external memory pin interface between two requesters. Requester 0 is the CPU load/store/fetch path. Requester 1 is the debug/loader port.
- Round-robin arbitration, one transaction in flight, fixed access sequencing with a parameterised read latency.
- Sits between the CPU core and the top-level pins: address on uo_out, read data from ui_in, write data on uio_out/uio_oe.

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter for the external memory pins.
// Optional MEMARB_LOCK_EN adds lock_0/lock_1 so a requester can keep the bus.
module mem_bus_arbiter #(
   parameter int RD_LAT = 1,
   parameter int AW     = 8,
   parameter int DW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_0,
   input  logic          req_1,
   input  logic          we_0,
   input  logic          we_1,
   input  logic [AW-1:0] addr_0,
   input  logic [AW-1:0] addr_1,
   input  logic [DW-1:0] wdata_0,
   input  logic [DW-1:0] wdata_1,
`ifdef MEMARB_LOCK_EN
   input  logic          lock_0,
   input  logic          lock_1,
`endif
   output logic          gnt_0,
   output logic          gnt_1,
   output logic          ack_0,
   output logic          ack_1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] ext_addr,
   output logic          ext_rd,
   output logic          ext_wr,
   output logic [DW-1:0] ext_wdata,
   output logic [DW-1:0] ext_wdata_oe,
   input  logic [DW-1:0] ext_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   // last read cycle index; counter is 2 bits since RD_LAT is 1..4
   localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

   state_t        state;
   state_t        state_n;
   logic          last;
   logic          id;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    cnt;
   logic          take;
   logic          win;
   logic          keep_last;
   logic          acc;
   logic          rd_done;
   logic          lock_hold;
   logic          lock_now;

   assign acc     = (state == ACCESS);
   assign rd_done = acc && !we_q && (cnt == CNT_LAST);

`ifdef MEMARB_LOCK_EN
   assign lock_now = id ? lock_1 : lock_0;
`else
   assign lock_now = 1'b0;
`endif

   // next-state and arbitration decision
   always_comb begin
      state_n   = state;
      take      = 1'b0;
      win       = 1'b0;
      keep_last = 1'b0;
      unique case (state)
         IDLE: begin
            if (lock_hold && (id ? req_1 : req_0)) begin
               take      = 1'b1;
               win       = id;
               keep_last = 1'b1;
            end else if (req_0 && req_1) begin
               take = 1'b1;
               win  = ~last;
            end else if (req_0) begin
               take = 1'b1;
               win  = 1'b0;
            end else if (req_1) begin
               take = 1'b1;
               win  = 1'b1;
            end
            if (take) begin
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q || rd_done) begin
               state_n = ACK;
            end
         end
         ACK: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // state register, request latch, read counter and data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         id        <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         rdata     <= '0;
         lock_hold <= 1'b0;
      end else begin
         state <= state_n;
         if (take) begin
            id      <= win;
            we_q    <= win ? we_1 : we_0;
            addr_q  <= win ? addr_1 : addr_0;
            wdata_q <= win ? wdata_1 : wdata_0;
            cnt     <= '0;
            if (!keep_last) begin
               last <= win;
            end
         end
         if (acc) begin
            cnt <= cnt + 2'd1;
         end
         if (rd_done) begin
            rdata <= ext_rdata;
         end
         if (state == ACK) begin
            lock_hold <= lock_now;
         end else if (state == IDLE) begin
            lock_hold <= 1'b0;
         end
      end
   end

   // pin drive and handshake pulses decoded from registered state
   always_comb begin
      busy         = (state != IDLE);
      ext_wr       = acc && we_q;
      ext_rd       = acc && !we_q;
      ext_addr     = acc ? addr_q : '0;
      ext_wdata    = ext_wr ? wdata_q : '0;
      ext_wdata_oe = ext_wr ? '1 : '0;
      gnt_0        = acc && (cnt == 2'd0) && !id;
      gnt_1        = acc && (cnt == 2'd0) && id;
      ack_0        = (state == ACK) && !id;
      ack_1        = (state == ACK) && id;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks for mem_bus_arbiter.
// Two instances: RD_LAT=1 (u_dut) and RD_LAT=3 (u_dut3).
module tb_mem_bus_arbiter;

   logic       clk;
   logic       rst_n;

   logic       req_0, req_1, we_0, we_1;
   logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
   logic       lock_0, lock_1;
   logic       gnt_0, gnt_1, ack_0, ack_1, busy;
   logic [7:0] rdata, ext_addr, ext_wdata, ext_wdata_oe, ext_rdata;
   logic       ext_rd, ext_wr;

   logic       req_0_3, req_1_3, we_0_3, we_1_3;
   logic [7:0] addr_0_3, addr_1_3, wdata_0_3, wdata_1_3;
   logic       gnt_0_3, gnt_1_3, ack_0_3, ack_1_3, busy_3;
   logic [7:0] rdata_3, ext_addr_3, ext_wdata_3, ext_wdata_oe_3, ext_rdata_3;
   logic       ext_rd_3, ext_wr_3;

   logic [7:0] mem [256];

   int n_checks;
   int n_err;

   assign ext_rdata   = mem[ext_addr];
   assign ext_rdata_3 = mem[ext_addr_3];

   mem_bus_arbiter #(.RD_LAT(1), .AW(8), .DW(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
      .addr_0(addr_0), .addr_1(addr_1),
      .wdata_0(wdata_0), .wdata_1(wdata_1),
`ifdef MEMARB_LOCK_EN
      .lock_0(lock_0), .lock_1(lock_1),
`endif
      .gnt_0(gnt_0), .gnt_1(gnt_1), .ack_0(ack_0), .ack_1(ack_1),
      .rdata(rdata), .busy(busy), .ext_addr(ext_addr),
      .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_wdata(ext_wdata),
      .ext_wdata_oe(ext_wdata_oe), .ext_rdata(ext_rdata)
   );

   mem_bus_arbiter #(.RD_LAT(3), .AW(8), .DW(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_0(req_0_3), .req_1(req_1_3), .we_0(we_0_3), .we_1(we_1_3),
      .addr_0(addr_0_3), .addr_1(addr_1_3),
      .wdata_0(wdata_0_3), .wdata_1(wdata_1_3),
`ifdef MEMARB_LOCK_EN
      .lock_0(1'b0), .lock_1(1'b0),
`endif
      .gnt_0(gnt_0_3), .gnt_1(gnt_1_3), .ack_0(ack_0_3), .ack_1(ack_1_3),
      .rdata(rdata_3), .busy(busy_3), .ext_addr(ext_addr_3),
      .ext_rd(ext_rd_3), .ext_wr(ext_wr_3), .ext_wdata(ext_wdata_3),
      .ext_wdata_oe(ext_wdata_oe_3), .ext_rdata(ext_rdata_3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ng;
      int         nrd;
      int         ack_c;
      int         gnt_c;
      int         ng1;
      int         nack;
      logic [3:0] seq;
      logic       lastg;
      logic [7:0] rd_v;

      n_checks = 0;
      n_err    = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'h10] = 8'hA5;
      mem[8'h05] = 8'h77;

      rst_n = 1'b0;
      {req_0, req_1, we_0, we_1, lock_0, lock_1} = '0;
      {addr_0, addr_1, wdata_0, wdata_1} = '0;
      {req_0_3, req_1_3, we_0_3, we_1_3} = '0;
      {addr_0_3, addr_1_3, wdata_0_3, wdata_1_3} = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt", 32'({gnt_0, gnt_1}), 0);
      check("rst_ack", 32'({ack_0, ack_1}), 0);
      check("rst_strobe", 32'({ext_rd, ext_wr}), 0);
      check("rst_addr", 32'(ext_addr), 0);
      check("rst_oe", 32'(ext_wdata_oe), 0);
      check("rst_rdata", 32'(rdata), 0);

      // single read, RD_LAT=1
      rst_n  = 1'b1;
      req_0  = 1'b1;
      we_0   = 1'b0;
      addr_0 = 8'h10;
      check("rd_c0_gnt", 32'(gnt_0), 0);
      tick();
      check("rd_c1_gnt", 32'(gnt_0), 1);
      check("rd_c1_extrd", 32'(ext_rd), 1);
      check("rd_c1_addr", 32'(ext_addr), 'h10);
      check("rd_c1_busy", 32'(busy), 1);
      req_0 = 1'b0;
      tick();
      check("rd_c2_ack", 32'(ack_0), 1);
      check("rd_c2_rdata", 32'(rdata), 'hA5);
      check("rd_c2_extrd", 32'(ext_rd), 0);
      tick();
      check("rd_c3_busy", 32'(busy), 0);
      check("rd_c3_hold", 32'(rdata), 'hA5);

      // single write by requester 1
      req_1   = 1'b1;
      we_1    = 1'b1;
      addr_1  = 8'h20;
      wdata_1 = 8'h3C;
      tick();
      check("wr_c1_gnt", 32'({gnt_0, gnt_1}), 1);
      check("wr_c1_wr", 32'(ext_wr), 1);
      check("wr_c1_rd", 32'(ext_rd), 0);
      check("wr_c1_addr", 32'(ext_addr), 'h20);
      check("wr_c1_wdata", 32'(ext_wdata), 'h3C);
      check("wr_c1_oe", 32'(ext_wdata_oe), 'hFF);
      req_1   = 1'b0;
      addr_1  = 8'hFF;
      wdata_1 = 8'h00;
      tick();
      check("wr_c2_ack", 32'({ack_0, ack_1}), 1);
      check("wr_c2_wr", 32'(ext_wr), 0);
      check("wr_c2_oe", 32'(ext_wdata_oe), 0);
      check("wr_c2_addr", 32'(ext_addr), 0);
      check("wr_c2_wdata", 32'(ext_wdata), 0);
      tick();
      check("wr_c3_busy", 32'(busy), 0);

      // contention: both requesters write continuously
      req_0 = 1'b1;
      req_1 = 1'b1;
      we_0  = 1'b1;
      we_1  = 1'b1;
      addr_0 = 8'h30;
      addr_1 = 8'h31;
      ng    = 0;
      seq   = '0;
      lastg = 1'b0;
      for (int c = 0; c < 12; c++) begin
         check("ct_two_gnt", 32'(gnt_0 & gnt_1), 0);
         check("ct_rd_wr", 32'(ext_rd & ext_wr), 0);
         if (gnt_0 | gnt_1) begin
            if (ng < 4) seq[ng] = gnt_1;
            ng++;
            lastg = gnt_1;
         end
         if (ack_0 | ack_1) check("ct_ack_id", 32'(ack_1), 32'(lastg));
         tick();
      end
      req_0 = 1'b0;
      req_1 = 1'b0;
      check("ct_ngnt", 32'(ng), 4);
      check("ct_seq", 32'(seq), 'b1010);
      tick();
      check("ct_idle", 32'(busy), 0);

      // RD_LAT=3 read with a withdrawn request from port 1
      req_0_3  = 1'b1;
      we_0_3   = 1'b0;
      addr_0_3 = 8'h05;
      nrd   = 0;
      ack_c = -1;
      gnt_c = -1;
      ng1   = 0;
      rd_v  = '0;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) req_0_3 = 1'b0;
         if (c == 2) req_1_3 = 1'b1;
         if (c == 3) req_1_3 = 1'b0;
         if (ext_rd_3) nrd++;
         if (gnt_0_3) gnt_c = c;
         if (gnt_1_3) ng1++;
         if (ack_0_3) begin
            ack_c = c;
            rd_v  = rdata_3;
         end
         tick();
      end
      check("l3_gnt_cyc", 32'(gnt_c), 1);
      check("l3_rd_cycles", 32'(nrd), 3);
      check("l3_ack_cyc", 32'(ack_c), 4);
      check("l3_rdata", 32'(rd_v), 'h77);
      check("l3_withdrawn", 32'(ng1), 0);

      // reset during a read access from port 0
      req_0_3  = 1'b1;
      addr_0_3 = 8'h05;
      tick();
      check("ra_gnt", 32'(gnt_0_3), 1);
      req_0_3 = 1'b0;
      tick();
      check("ra_pre_rd", 32'(ext_rd_3), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ra_async_rd", 32'(ext_rd_3), 0);
      check("ra_async_busy", 32'(busy_3), 0);
      check("ra_async_addr", 32'(ext_addr_3), 0);
      nack = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (ack_0_3 | ack_1_3) nack++;
      end
      check("ra_no_ack", 32'(nack), 0);
      rst_n   = 1'b1;
      req_0_3 = 1'b1;
      req_1_3 = 1'b1;
      we_0_3  = 1'b1;
      we_1_3  = 1'b1;
      tick();
      check("ra_first_gnt", 32'({gnt_1_3, gnt_0_3}), 'b01);
      req_0_3 = 1'b0;
      req_1_3 = 1'b0;
      tick();
      check("ra_no_ack_late", 32'(ack_1_3), 0);
      tick();

`ifdef MEMARB_LOCK_EN
      // locked burst by port 1 while port 0 waits
      req_1  = 1'b1;
      we_1   = 1'b1;
      lock_1 = 1'b1;
      ng  = 0;
      seq = '0;
      for (int c = 0; c < 12; c++) begin
         if (c == 1) begin
            req_0 = 1'b1;
            we_0  = 1'b1;
         end
         if (c == 7) lock_1 = 1'b0;
         if (gnt_0 | gnt_1) begin
            if (ng < 4) seq[ng] = gnt_1;
            ng++;
         end
         tick();
      end
      req_0 = 1'b0;
      req_1 = 1'b0;
      check("lk_ngnt", 32'(ng), 4);
      check("lk_seq", 32'(seq), 'b0111);
      repeat (3) tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
